// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned XLEN  = 32;
  // Wide enough for MAX_OUTSTANDING up to 7.
  localparam int unsigned OUT_W = 3;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifq_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// In-order entry store for fetched instructions: push at tail, pop at head,
// flush clears everything. Synchronous active-low reset.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  ifq_entry_t              push_data,
  input  logic                    pop,
  output ifq_entry_t              head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers in-order
// responses, presents them to the core, and flushes/restarts on redirect.
// Optional feature macro: IFQ_PERF_EN adds stall_cnt / drop_cnt counters.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fpc_q, fpc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] discard_q, discard_d;

  logic             fifo_flush;
  logic             fifo_push;
  logic             fifo_pop;
  ifq_entry_t       fifo_wdata;
  ifq_entry_t       fifo_head;
  logic [CW-1:0]    fifo_count;

  logic             credit_ok;
  logic             req_fire;

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Credit: every queued or in-flight instruction reserves a queue slot.
  always_comb begin
    credit_ok = (outstanding_q < OUT_W'(MAX_OUTSTANDING)) &&
                ((32'(fifo_count) + 32'(outstanding_q)) < 32'(DEPTH));
  end

  assign imem_req_valid = reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign instr_valid    = (fifo_count != '0);

  // Head presentation; an empty queue shows a NOP at the expected PC.
  always_comb begin
    InstrF = NOP_INSTR;
    PCF    = epc_q;
    if (instr_valid) begin
      InstrF = fifo_head.instr;
      PCF    = fifo_head.pc;
    end
  end

  // Fetch control: credit, discard bookkeeping, PCs and queue commands.
  always_comb begin
    fpc_d         = fpc_q;
    epc_d         = epc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fifo_flush    = 1'b0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_wdata    = '{pc: epc_q, instr: imem_rsp_data};
    if (redirect_valid) begin
      // Everything still in flight after this cycle must be thrown away.
      fifo_flush    = 1'b1;
      fpc_d         = word_align(redirect_pc);
      epc_d         = word_align(redirect_pc);
      outstanding_d = outstanding_q - OUT_W'(imem_rsp_valid);
      discard_d     = outstanding_q - OUT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fpc_d = fpc_q + 32'd4;
      end
      fifo_pop      = instr_valid && instr_ready;
      outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - OUT_W'(1);
        end else begin
          fifo_push = 1'b1;
          epc_d     = epc_q + 32'd4;
        end
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc_q         <= RESET_PC;
      epc_q         <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fpc_q         <= fpc_d;
      epc_q         <= epc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] drop_q, drop_d;
  logic        drop_event;

  // Saturating event counters for fetch stalls and discarded responses.
  always_comb begin
    stall_d    = stall_q;
    drop_d     = drop_q;
    drop_event = imem_rsp_valid && (redirect_valid || (discard_q != '0));
    if (instr_valid && !instr_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (drop_event && (drop_q != 32'hFFFF_FFFF)) begin
      drop_d = drop_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  assign stall_cnt = stall_q;
  assign drop_cnt  = drop_q;
`else
  // Counters absent in this build.
`endif

endmodule
